// File: rtl/writeback_latch_repne_wb_pkg.sv
// writeback_latch_repne_wb_pkg: shared REPNE FSM encoding, flag/count constants and WB control bundle.
package writeback_latch_repne_wb_pkg;
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_STEADY = 2'b01;
    localparam logic [1:0] ST_TERM   = 2'b10;
    localparam int ZF_BIT       = 6;
    localparam int DATA_W_DEF   = 32;
    localparam int COUNT_ZERO_W_DEF = 32;
    typedef struct packed {
        logic v;
        logic gpr1;
        logic gpr2;
        logic dcw;
        logic rep;
        logic cmps;
    } wb_ctl_t;
endpackage

// File: rtl/writeback_latch_repne_wb_if.sv
// writeback_latch_repne_wb_if: EX->WB next-value bus, dcache handshake and WB/REPNE outputs.
interface writeback_latch_repne_wb_if #(parameter int DATA_W = 32);
    logic              WB_V_next;
    logic [DATA_W-1:0] WB_RESULT_A_next;
    logic [DATA_W-1:0] WB_RESULT_B_next;
    logic [DATA_W-1:0] WB_RESULT_C_next;
    logic [DATA_W-1:0] WB_FLAGS_next;
    logic              v_ex_ld_gpr1;
    logic              v_ex_ld_gpr2;
    logic              v_ex_dcache_write;
    logic              WB_de_repne_all_next;
    logic              CS_IS_CMPS_SECOND_UOP_next;
    logic              dcache_write_ready;
    logic              WB_V;
    logic [DATA_W-1:0] WB_RESULT_A;
    logic [DATA_W-1:0] WB_RESULT_B;
    logic [DATA_W-1:0] WB_RESULT_C;
    logic [DATA_W-1:0] WB_FLAGS;
    logic              wb_ld_gpr1;
    logic              wb_ld_gpr2;
    logic              dcache_write_req;
    logic              WB_Stall;
    logic [DATA_W-1:0] count_dataforwarded;
    logic [DATA_W-1:0] flags_dataforwarded;
    logic              EX_REPNE_STEADY_STATE_EX;
    logic              wb_repne_terminate_all;
    modport master (
        output WB_V_next, WB_RESULT_A_next, WB_RESULT_B_next, WB_RESULT_C_next, WB_FLAGS_next,
        output v_ex_ld_gpr1, v_ex_ld_gpr2, v_ex_dcache_write, WB_de_repne_all_next,
        output CS_IS_CMPS_SECOND_UOP_next, dcache_write_ready,
        input  WB_V, WB_RESULT_A, WB_RESULT_B, WB_RESULT_C, WB_FLAGS, wb_ld_gpr1, wb_ld_gpr2,
        input  dcache_write_req, WB_Stall, count_dataforwarded, flags_dataforwarded,
        input  EX_REPNE_STEADY_STATE_EX, wb_repne_terminate_all
    );
    modport slave (
        input  WB_V_next, WB_RESULT_A_next, WB_RESULT_B_next, WB_RESULT_C_next, WB_FLAGS_next,
        input  v_ex_ld_gpr1, v_ex_ld_gpr2, v_ex_dcache_write, WB_de_repne_all_next,
        input  CS_IS_CMPS_SECOND_UOP_next, dcache_write_ready,
        output WB_V, WB_RESULT_A, WB_RESULT_B, WB_RESULT_C, WB_FLAGS, wb_ld_gpr1, wb_ld_gpr2,
        output dcache_write_req, WB_Stall, count_dataforwarded, flags_dataforwarded,
        output EX_REPNE_STEADY_STATE_EX, wb_repne_terminate_all
    );
endinterface

// File: rtl/writeback_latch_repne_wb_repne_fsm_wb.sv
// repne_fsm_wb: REPNE sequencer; detects loop end from the latched WB uop and advances only when unstalled.
module repne_fsm_wb
    import writeback_latch_repne_wb_pkg::*;
#(
    parameter int COUNT_ZERO_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    v,
    input  logic                    rep,
    input  logic                    cmps,
    input  logic                    zf,
    input  logic [COUNT_ZERO_W-1:0] count_lo,
    output logic                    steady,
    output logic                    terminate
);
    logic [1:0] state_d, state_q;
    logic       term;
    always_comb begin
        term    = v & rep & ((count_lo == '0) | (cmps & zf));
        state_d = !en                   ? state_q :
                  (state_q == ST_TERM)  ? ST_IDLE :
                  term                  ? ST_TERM :
                  (state_q == ST_STEADY) ? (v ? ST_STEADY : ST_IDLE) :
                  (v & rep)             ? ST_STEADY : ST_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end
    assign steady    = (state_q == ST_STEADY);
    assign terminate = (state_q == ST_TERM);
endmodule

// File: rtl/writeback_latch_repne_wb.sv
// writeback_latch_repne_wb: WB pipeline latches, dcache write handshake/stall and REPNE forwarding to EX.
module writeback_latch_repne_wb
    import writeback_latch_repne_wb_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int COUNT_ZERO_W = COUNT_ZERO_W_DEF
) (
    input  logic                        CLK,
    input  logic                        CLR,
    writeback_latch_repne_wb_if.slave   bus
);
    wb_ctl_t           ctl_d, ctl_q;
    logic [DATA_W-1:0] a_d, a_q, b_d, b_q, c_d, c_q, flags_d, flags_q;
    logic              stall;
    assign stall = ctl_q.v & ctl_q.dcw & ~bus.dcache_write_ready;
    // Bubbles load too; they simply clear valid.
    always_comb begin
        ctl_d   = stall ? ctl_q : {bus.WB_V_next, bus.v_ex_ld_gpr1, bus.v_ex_ld_gpr2,
                                   bus.v_ex_dcache_write, bus.WB_de_repne_all_next,
                                   bus.CS_IS_CMPS_SECOND_UOP_next};
        a_d     = stall ? a_q     : bus.WB_RESULT_A_next;
        b_d     = stall ? b_q     : bus.WB_RESULT_B_next;
        c_d     = stall ? c_q     : bus.WB_RESULT_C_next;
        flags_d = stall ? flags_q : bus.WB_FLAGS_next;
    end
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            ctl_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            flags_q <= '0;
        end else begin
            ctl_q   <= ctl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end
    repne_fsm_wb #(.COUNT_ZERO_W(COUNT_ZERO_W)) u_fsm (
        .clk       (CLK),
        .rst_n     (CLR),
        .en        (~stall),
        .v         (ctl_q.v),
        .rep       (ctl_q.rep),
        .cmps      (ctl_q.cmps),
        .zf        (flags_q[ZF_BIT]),
        .count_lo  (c_q[COUNT_ZERO_W-1:0]),
        .steady    (bus.EX_REPNE_STEADY_STATE_EX),
        .terminate (bus.wb_repne_terminate_all)
    );
    assign bus.WB_V                = ctl_q.v;
    assign bus.WB_RESULT_A         = a_q;
    assign bus.WB_RESULT_B         = b_q;
    assign bus.WB_RESULT_C         = c_q;
    assign bus.WB_FLAGS            = flags_q;
    assign bus.wb_ld_gpr1          = ctl_q.v & ctl_q.gpr1 & ~stall;
    assign bus.wb_ld_gpr2          = ctl_q.v & ctl_q.gpr2 & ~stall;
    assign bus.dcache_write_req    = ctl_q.v & ctl_q.dcw;
    assign bus.WB_Stall            = stall;
    assign bus.count_dataforwarded = c_q;
    assign bus.flags_dataforwarded = flags_q;
endmodule

// File: tb/tb_writeback_latch_repne_wb.sv
// tb_writeback_latch_repne_wb: directed vector table, hand sequences and random run against a WB/REPNE reference model.
module tb_writeback_latch_repne_wb;
    logic CLK = 1'b0;
    logic CLR = 1'b0;
    always #5 CLK = ~CLK;

    writeback_latch_repne_wb_if #(.DATA_W(32)) bus ();
    writeback_latch_repne_wb dut (.CLK(CLK), .CLR(CLR), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic v; logic [31:0] a; logic [31:0] c; logic [31:0] f;
        logic g1; logic dw; logic rep; logic cmps; logic rdy;
        logic e_v; logic [31:0] e_a; logic e_ld1; logic e_stall; logic e_steady; logic e_term;
    } vec_t;
    vec_t vt[19];

    // reference model: latched uop plus "inside a REPNE loop" and "terminate pending" flags
    logic        m_v, m_g1, m_g2, m_dw, m_rep, m_cmps, m_loop, m_pulse;
    logic [31:0] m_a, m_b, m_c, m_f;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        {m_v, m_g1, m_g2, m_dw, m_rep, m_cmps, m_loop, m_pulse} = '0;
        {m_a, m_b, m_c, m_f} = '0;
    endtask

    function automatic logic m_stall();
        return m_v & m_dw & ~bus.dcache_write_ready;
    endfunction

    task automatic model_edge();
        logic ends;
        if (m_stall()) return;
        ends = m_v && m_rep && (m_c == 32'd0 || (m_cmps && m_f[6]));
        if (m_pulse) begin
            m_pulse = 1'b0; m_loop = 1'b0;
        end else if (ends) begin
            m_pulse = 1'b1; m_loop = 1'b0;
        end else begin
            m_loop = m_loop ? m_v : (m_v & m_rep);
        end
        m_v = bus.WB_V_next; m_a = bus.WB_RESULT_A_next; m_b = bus.WB_RESULT_B_next;
        m_c = bus.WB_RESULT_C_next; m_f = bus.WB_FLAGS_next;
        m_g1 = bus.v_ex_ld_gpr1; m_g2 = bus.v_ex_ld_gpr2; m_dw = bus.v_ex_dcache_write;
        m_rep = bus.WB_de_repne_all_next; m_cmps = bus.CS_IS_CMPS_SECOND_UOP_next;
    endtask

    task automatic check_model();
        chk("wb_v", {31'd0, bus.WB_V}, {31'd0, m_v});
        chk("res_a", bus.WB_RESULT_A, m_a);
        chk("res_b", bus.WB_RESULT_B, m_b);
        chk("res_c", bus.WB_RESULT_C, m_c);
        chk("flags", bus.WB_FLAGS, m_f);
        chk("ld_gpr1", {31'd0, bus.wb_ld_gpr1}, {31'd0, m_v & m_g1 & ~m_stall()});
        chk("ld_gpr2", {31'd0, bus.wb_ld_gpr2}, {31'd0, m_v & m_g2 & ~m_stall()});
        chk("dc_req", {31'd0, bus.dcache_write_req}, {31'd0, m_v & m_dw});
        chk("stall", {31'd0, bus.WB_Stall}, {31'd0, m_stall()});
        chk("cnt_fwd", bus.count_dataforwarded, m_c);
        chk("flg_fwd", bus.flags_dataforwarded, m_f);
        chk("steady", {31'd0, bus.EX_REPNE_STEADY_STATE_EX}, {31'd0, m_loop});
        chk("term", {31'd0, bus.wb_repne_terminate_all}, {31'd0, m_pulse});
    endtask

    task automatic check_all_zero();
        chk("rst_v", {31'd0, bus.WB_V}, 32'd0);
        chk("rst_a", bus.WB_RESULT_A, 32'd0);
        chk("rst_b", bus.WB_RESULT_B, 32'd0);
        chk("rst_c", bus.WB_RESULT_C, 32'd0);
        chk("rst_f", bus.WB_FLAGS, 32'd0);
        chk("rst_ctl", {26'd0, bus.wb_ld_gpr1, bus.wb_ld_gpr2, bus.dcache_write_req,
            bus.WB_Stall, bus.EX_REPNE_STEADY_STATE_EX, bus.wb_repne_terminate_all}, 32'd0);
        chk("rst_fwd", bus.count_dataforwarded | bus.flags_dataforwarded, 32'd0);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] f, input logic g1,
                         input logic g2, input logic dw, input logic rep, input logic cmps,
                         input logic rdy);
        bus.WB_V_next = v; bus.WB_RESULT_A_next = a; bus.WB_RESULT_B_next = b;
        bus.WB_RESULT_C_next = c; bus.WB_FLAGS_next = f; bus.v_ex_ld_gpr1 = g1;
        bus.v_ex_ld_gpr2 = g2; bus.v_ex_dcache_write = dw; bus.WB_de_repne_all_next = rep;
        bus.CS_IS_CMPS_SECOND_UOP_next = cmps; bus.dcache_write_ready = rdy;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1, 32'h1234_5678, 7, 0, 1, 0, 0, 0, 1,  1, 32'h1234_5678, 1, 0, 0, 0};
        vt[1]  = '{1, 32'hAAAA_0001, 7, 0, 1, 1, 0, 0, 0,  1, 32'hAAAA_0001, 0, 1, 0, 0};
        vt[2]  = '{1, 32'hBBBB_0002, 7, 0, 1, 0, 0, 0, 0,  1, 32'hAAAA_0001, 0, 1, 0, 0};
        vt[3]  = '{1, 32'hBBBB_0002, 7, 0, 1, 0, 0, 0, 0,  1, 32'hAAAA_0001, 0, 1, 0, 0};
        vt[4]  = '{1, 32'hBBBB_0002, 7, 0, 1, 0, 0, 0, 1,  1, 32'hBBBB_0002, 1, 0, 0, 0};
        vt[5]  = '{1, 0, 3, 0, 0, 0, 1, 0, 1,              1, 0, 0, 0, 0, 0};
        vt[6]  = '{1, 0, 2, 0, 0, 0, 1, 0, 1,              1, 0, 0, 0, 1, 0};
        vt[7]  = '{1, 0, 1, 0, 0, 0, 1, 0, 1,              1, 0, 0, 0, 1, 0};
        vt[8]  = '{1, 0, 0, 0, 0, 0, 1, 0, 1,              1, 0, 0, 0, 1, 0};
        vt[9]  = '{1, 0, 9, 0, 0, 0, 0, 0, 1,              1, 0, 0, 0, 0, 1};
        vt[10] = '{0, 0, 9, 0, 0, 0, 0, 0, 1,              0, 0, 0, 0, 0, 0};
        vt[11] = '{1, 0, 5, 0, 0, 0, 1, 1, 1,              1, 0, 0, 0, 0, 0};
        vt[12] = '{1, 0, 4, 32'h40, 0, 0, 1, 1, 1,         1, 0, 0, 0, 1, 0};
        vt[13] = '{1, 0, 3, 0, 0, 0, 0, 0, 1,              1, 0, 0, 0, 0, 1};
        vt[14] = '{0, 0, 3, 0, 0, 0, 0, 0, 1,              0, 0, 0, 0, 0, 0};
        vt[15] = '{1, 0, 8, 0, 0, 0, 1, 0, 1,              1, 0, 0, 0, 0, 0};
        vt[16] = '{1, 0, 7, 0, 0, 0, 1, 0, 1,              1, 0, 0, 0, 1, 0};
        vt[17] = '{0, 0, 7, 0, 0, 0, 1, 0, 1,              0, 0, 0, 0, 1, 0};
        vt[18] = '{0, 0, 7, 0, 0, 0, 0, 0, 1,              0, 0, 0, 0, 0, 0};

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_reset();
        #2;
        check_all_zero();
        #10 CLR = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].v, vt[i].a, 32'h0, vt[i].c, vt[i].f, vt[i].g1, 1'b0, vt[i].dw,
                  vt[i].rep, vt[i].cmps, vt[i].rdy);
            step();
            chk($sformatf("vec%0d_v", i), {31'd0, bus.WB_V}, {31'd0, vt[i].e_v});
            chk($sformatf("vec%0d_a", i), bus.WB_RESULT_A, vt[i].e_a);
            chk($sformatf("vec%0d_ld1", i), {31'd0, bus.wb_ld_gpr1}, {31'd0, vt[i].e_ld1});
            chk($sformatf("vec%0d_stall", i), {31'd0, bus.WB_Stall}, {31'd0, vt[i].e_stall});
            chk($sformatf("vec%0d_steady", i), {31'd0, bus.EX_REPNE_STEADY_STATE_EX}, {31'd0, vt[i].e_steady});
            chk($sformatf("vec%0d_term", i), {31'd0, bus.wb_repne_terminate_all}, {31'd0, vt[i].e_term});
        end

        // loop end coinciding with a dcache stall: terminate waits for the release
        drive(1, 32'h55, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(); check_model();
        drive(1, 32'h66, 0, 4, 0, 0, 0, 0, 0, 0, 0);
        step(); check_model();
        chk("term_held", {31'd0, bus.wb_repne_terminate_all}, 32'd0);
        drive(1, 32'h66, 0, 4, 0, 0, 0, 0, 0, 0, 1);
        step(); check_model();
        chk("term_after_release", {31'd0, bus.wb_repne_terminate_all}, 32'd1);
        chk("a_after_release", bus.WB_RESULT_A, 32'h66);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(); check_model();

        // asynchronous clear in the middle of a steady REPNE loop
        drive(1, 0, 0, 5, 0, 1, 1, 0, 1, 0, 1);
        step(); step(); check_model();
        chk("pre_clr_steady", {31'd0, bus.EX_REPNE_STEADY_STATE_EX}, 32'd1);
        #2 CLR = 1'b0;
        #1;
        check_all_zero();
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #3 CLR = 1'b1;
        step(); check_model();

        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? 32'h40 : 32'h0,
                  1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
            step();
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/writeback_latch_repne_wb.md
Name: writeback_latch_repne_wb

Overview:
- Consumer side of the EX→WB interface. Holds the WB pipeline latches that EX computes next-values for, and drives the dcache write request handshake.
- Generates WB_Stall back to EX.
- Runs the REPNE sequencer that EX consumes: EX_REPNE_STEADY_STATE_EX, count_dataforwarded, flags_dataforwarded and wb_repne_terminate_all.

Parameters:
- DATA_W, 32, width of WB result and flag latches.
- COUNT_ZERO_W, 32, number of low count bits examined for the REPNE zero test.

Ports:
- CLK  in  1  pipeline clock.
- CLR  in  1  asynchronous active-low reset.
- WB_V_next  in  1  valid from EX.
- WB_RESULT_A_next/B_next/C_next  in  32 each  EX results; C is the decremented count for string uops.
- WB_FLAGS_next  in  32  EX flags (ZF = bit 6).
- v_ex_ld_gpr1/v_ex_ld_gpr2/v_ex_dcache_write  in  1 each  validated EX controls.
- WB_de_repne_all_next  in  1  uop carries REPNE prefix.
- CS_IS_CMPS_SECOND_UOP_next  in  1  uop is the compare half of CMPS (ZF terminates).
- dcache_write_ready  in  1  dcache accepts the write this cycle.
- WB_V  out  1  latched valid.
- WB_RESULT_A/B/C, WB_FLAGS  out  32 each  latched values.
- wb_ld_gpr1/wb_ld_gpr2  out  1 each  gated GPR write enables.
- dcache_write_req  out  1  write request.
- WB_Stall  out  1  to EX.
- count_dataforwarded, flags_dataforwarded  out  32 each  forwarding to EX.
- EX_REPNE_STEADY_STATE_EX  out  1  EX must use the forwarded count.
- wb_repne_terminate_all  out  1  REPNE loop end.

Behaviour:
- Reset (CLR=0, async): all latches 0, WB_V=0, FSM=IDLE. Every output is then 0.
- Latch load: on posedge CLK when WB_Stall=0, every *_next input is captured. When WB_Stall=1, all latches hold.
- WB_V_next=0 still loads. The bubble clears WB_V, and the data latches load don't-care values.
- Write enables: wb_ld_gpr1 = WB_V & latched gpr1, gated off while WB_Stall=1. Same for gpr2.
- dcache_write_req = WB_V & latched dcache_write.
- WB_Stall = dcache_write_req & ~dcache_write_ready. The stall is released in the same cycle ready rises, so the latches load on that edge. Single-cycle accept, no extra bubble.
- Forwarding (combinational from the latches):
  - count_dataforwarded = WB_RESULT_C.
  - flags_dataforwarded = WB_FLAGS.
- term = WB_V & rep & ((WB_RESULT_C[COUNT_ZERO_W-1:0]==0) | (cmps & WB_FLAGS[6])), using the latched rep and cmps bits.
- FSM states IDLE, STEADY, TERM. Transitions occur only on edges where WB_Stall=0; otherwise the state holds.
  - IDLE: if WB_V & rep & ~term → STEADY; if term → TERM.
  - STEADY: EX_REPNE_STEADY_STATE_EX=1. If term → TERM; if WB_V=0 (flush/bubble) → IDLE; else stay.
  - TERM: wb_repne_terminate_all=1 for exactly one unstalled cycle → IDLE. EX_REPNE_STEADY_STATE_EX=0.
- wb_repne_terminate_all is 0 in IDLE and STEADY.
- Count wrap: a count of 0 entering EX decrements to 32'hFFFF_FFFF. This block only evaluates the latched count, so wrap cannot falsely terminate. An initial count of 0 is handled by decode and is outside this block.
- Simultaneous term & stall: TERM is entered only once the stall releases, so the terminate pulse never overlaps a held latch.
- CLR mid-loop forces IDLE immediately and drops EX_REPNE_STEADY_STATE_EX asynchronously.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'b00, STEADY=2'b01, TERM=2'b10), ZF bit index 6, count-zero width constant.
- One sub-module, repne_fsm_wb (state register plus the term and next-state logic). The latches and handshake stay in the top.

Test Plan:
- Reset: CLR=0 mid-cycle with STEADY active → all outputs 0 immediately; state IDLE after CLR=1.
- Plain write: WB_V_next=1, A=32'h1234_5678, gpr1=1, no dcache → after 1 edge WB_RESULT_A=32'h1234_5678, wb_ld_gpr1=1, WB_Stall=0.
- Dcache handshake: dcache_write=1, ready=0 for 3 cycles then 1 → WB_Stall high 3 cycles, latches hold, new next values captured on the edge when ready=1.
- REPNE count loop: rep=1, C sequence 3,2,1,0 → STEADY from the first edge, EX_REPNE_STEADY_STATE_EX=1, terminate pulses 1 cycle after C=0 latched, then IDLE.
- REPNE CMPS ZF: C=5, cmps=1, FLAGS=32'h40 on the second iteration → TERM with count 4, terminate one cycle, no further steady-state.
- Bubble in STEADY: WB_V_next=0 → IDLE next edge, steady-state deasserted, no terminate pulse.
